// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifter.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a combinational barrel shifter.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit IterShift = 1'b0;
`else
  localparam bit IterShift = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;
  logic [XLEN-1:0]     shiftReg_q, shiftReg_d;
  logic [SHAMT_W-1:0]  shiftCnt_q, shiftCnt_d;
  logic                shRight_q, shRight_d;
  logic                shArith_q, shArith_d;

  logic [SHAMT_W-1:0]  shamt;
  logic                isShift;
  logic                startIter;
  logic [XLEN-1:0]     aluRes;
  logic [XLEN-1:0]     immRes;
  logic [XLEN-1:0]     shiftStep;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign isShift   = (alu_ctrl == 4'b0001) || (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b1101);
  assign startIter = IterShift && isShift && (shamt != '0);
  // A zero-amount iterative shift completes straight from IDLE and returns op_a unchanged.
  assign immRes    = (IterShift && isShift) ? op_a : aluRes;
  assign shiftStep = shRight_q ? {shArith_q & shiftReg_q[XLEN-1], shiftReg_q[XLEN-1:1]}
                               : {shiftReg_q[XLEN-2:0], 1'b0};

  always_comb begin
    aluRes = op_a + op_b;
    case (alu_ctrl)
      4'b1000: aluRes = op_a - op_b;
      4'b0010: aluRes = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0011: aluRes = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b0100: aluRes = op_a ^ op_b;
      4'b0110: aluRes = op_a | op_b;
      4'b0111: aluRes = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
      4'b0001: aluRes = op_a << shamt;
      4'b0101: aluRes = op_a >> shamt;
      4'b1101: aluRes = $signed(op_a) >>> shamt;
`endif
      default: aluRes = op_a + op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      shiftReg_q <= '0;
      shiftCnt_q <= '0;
      shRight_q  <= 1'b0;
      shArith_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      shiftReg_q <= shiftReg_d;
      shiftCnt_q <= shiftCnt_d;
      shRight_q  <= shRight_d;
      shArith_q  <= shArith_d;
    end
  end

  // The last shift step writes the result directly so a shift of N bits takes N+1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = startIter ? SHIFT : DONE;
      SHIFT:   if (shiftCnt_q == SHAMT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d   = result_q;
    zero_d     = zero_q;
    shiftReg_d = shiftReg_q;
    shiftCnt_d = shiftCnt_q;
    shRight_d  = shRight_q;
    shArith_d  = shArith_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (startIter) begin
            shiftReg_d = op_a;
            shiftCnt_d = shamt;
            shRight_d  = alu_ctrl[2];
            shArith_d  = alu_ctrl[3];
          end else begin
            result_d = immRes;
            zero_d   = (immRes == '0);
          end
        end
      end
      SHIFT: begin
        shiftReg_d = shiftStep;
        shiftCnt_d = shiftCnt_q - SHAMT_W'(1);
        if (shiftCnt_q == SHAMT_W'(1)) begin
          result_d = shiftStep;
          zero_d   = (shiftStep == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    zero      = zero_q;
  end

endmodule
